fill_seal_controller: RTL and testbench

// - Parametrised Moore controller for one fill-and-seal station of the bottling line.
// - Adds timed fill/seal phases, a real bottle sensor with timeout, abort and fault handling,
//   and a saturating good-bottle counter.
// - Sits between the 1 Hz (or faster) clock domain and the valve/sealer actuators and status LEDs.

---
 rtl/fill_seal_controller.sv | 134 +++++++++++++
 tb/tb_fill_seal_controller.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fill_seal_controller.sv
// Moore fill-and-seal station controller: timed FILL/SEAL phases, sensor timeout, abort/fault, saturating count.
// Optional feature macro: AUTO_CYCLE_EN (DONE goes straight back to CHECK while start is held).
module fill_seal_controller #(
  parameter int FILL_CYCLES    = 4,
  parameter int SEAL_CYCLES    = 2,
  parameter int SENSOR_TIMEOUT = 3,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bottle_present,
  input  logic             abort,
  input  logic             clear_fault,
  output logic             fill_valve,
  output logic             sealer_on,
  output logic             done_pulse,
  output logic             fault,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] bottle_count
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_FILL  = 3'd2,
    ST_SEAL  = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  localparam int TMAX_A = (FILL_CYCLES > SEAL_CYCLES) ? FILL_CYCLES : SEAL_CYCLES;
  localparam int TMAX   = (TMAX_A > SENSOR_TIMEOUT) ? TMAX_A : SENSOR_TIMEOUT;
  localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]    FILL_LAST  = TW'(FILL_CYCLES - 1);
  localparam logic [TW-1:0]    SEAL_LAST  = TW'(SEAL_CYCLES - 1);
  localparam logic [TW-1:0]    CHECK_LAST = TW'(SENSOR_TIMEOUT - 1);
  localparam logic [TW-1:0]    TIMER_ONE  = TW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t            state_r;
  state_t            state_s;
  logic [TW-1:0]     timer_r;
  logic [CNT_W-1:0]  count_r;
  logic              fill_valve_r;
  logic              sealer_on_r;
  logic              done_pulse_r;
  logic              fault_r;
  logic [2:0]        state_o_r;

  // Next-state selection: abort first, then sensor, then phase timer.
  always_comb begin
    state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_CHECK;
        else       state_s = ST_IDLE;
      end
      ST_CHECK: begin
        if (abort)                     state_s = ST_FAULT;
        else if (bottle_present)       state_s = ST_FILL;
        else if (timer_r == CHECK_LAST) state_s = ST_FAULT;
        else                           state_s = ST_CHECK;
      end
      ST_FILL: begin
        if (abort || !bottle_present)  state_s = ST_FAULT;
        else if (timer_r == FILL_LAST) state_s = ST_SEAL;
        else                           state_s = ST_FILL;
      end
      ST_SEAL: begin
        if (abort || !bottle_present)  state_s = ST_FAULT;
        else if (timer_r == SEAL_LAST) state_s = ST_DONE;
        else                           state_s = ST_SEAL;
      end
      ST_DONE: begin
`ifdef AUTO_CYCLE_EN
        if (start) state_s = ST_CHECK;
        else       state_s = ST_IDLE;
`else
        state_s = ST_IDLE;
`endif
      end
      ST_FAULT: begin
        if (clear_fault && !abort) state_s = ST_IDLE;
        else                       state_s = ST_FAULT;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, phase timer and completed-bottle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      timer_r <= '0;
      count_r <= '0;
    end else begin
      state_r <= state_s;
      if (state_s != state_r) timer_r <= '0;
      else                    timer_r <= timer_r + TIMER_ONE;
      if ((state_s == ST_DONE) && (state_r != ST_DONE) && (count_r != CNT_MAX))
        count_r <= count_r + CNT_ONE;
      else
        count_r <= count_r;
    end
  end

  // Actuator/LED outputs registered from the next state so they track state_r exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_valve_r <= 1'b0;
      sealer_on_r  <= 1'b0;
      done_pulse_r <= 1'b0;
      fault_r      <= 1'b0;
      state_o_r    <= 3'd0;
    end else begin
      fill_valve_r <= (state_s == ST_FILL);
      sealer_on_r  <= (state_s == ST_SEAL);
      done_pulse_r <= (state_s == ST_DONE);
      fault_r      <= (state_s == ST_FAULT);
      state_o_r    <= state_s;
    end
  end

  assign fill_valve   = fill_valve_r;
  assign sealer_on    = sealer_on_r;
  assign done_pulse   = done_pulse_r;
  assign fault        = fault_r;
  assign state_o      = state_o_r;
  assign bottle_count = count_r;

endmodule

// File: tb/tb_fill_seal_controller.sv
// Self-checking bench for fill_seal_controller: vector table plus hand-written multi-cycle sequences.
module tb_fill_seal_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic bottle_present = 1'b0;
  logic abort = 1'b0;
  logic clear_fault = 1'b0;

  logic       fill_valve, sealer_on, done_pulse, fault;
  logic [2:0] state_o;
  logic [7:0] bottle_count;
  logic       fill_valve2, sealer_on2, done_pulse2, fault2;
  logic [2:0] state_o2;
  logic [1:0] bottle_count2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fill_seal_controller #(.FILL_CYCLES(4), .SEAL_CYCLES(2), .SENSOR_TIMEOUT(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .bottle_present(bottle_present), .abort(abort),
    .clear_fault(clear_fault), .fill_valve(fill_valve), .sealer_on(sealer_on),
    .done_pulse(done_pulse), .fault(fault), .state_o(state_o), .bottle_count(bottle_count));

  fill_seal_controller #(.FILL_CYCLES(4), .SEAL_CYCLES(2), .SENSOR_TIMEOUT(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .bottle_present(bottle_present), .abort(abort),
    .clear_fault(clear_fault), .fill_valve(fill_valve2), .sealer_on(sealer_on2),
    .done_pulse(done_pulse2), .fault(fault2), .state_o(state_o2), .bottle_count(bottle_count2));

  typedef struct {
    logic       s, b, a, c;
    logic [2:0] st;
    logic [7:0] cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic s, b, a, c, input logic [2:0] st, input logic [7:0] cnt);
    vec_t v;
    v.s = s; v.b = b; v.a = a; v.c = c; v.st = st; v.cnt = cnt;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Full output check; actuator expectations follow from the expected state code.
  task automatic chk_all(input string name, input logic [2:0] st, input logic [7:0] cnt);
    chk({name, ".state"}, {29'd0, state_o}, {29'd0, st});
    chk({name, ".fill"},  {31'd0, fill_valve}, {31'd0, st == 3'd2});
    chk({name, ".seal"},  {31'd0, sealer_on},  {31'd0, st == 3'd3});
    chk({name, ".done"},  {31'd0, done_pulse}, {31'd0, st == 3'd4});
    chk({name, ".fault"}, {31'd0, fault},      {31'd0, st == 3'd5});
    chk({name, ".count"}, {24'd0, bottle_count}, {24'd0, cnt});
  endtask

  task automatic step(input logic s, b, a, c);
    start = s; bottle_present = b; abort = a; clear_fault = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; bottle_present = 1'b0; abort = 1'b0; clear_fault = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_all("reset", 3'd0, 8'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One complete bottle from IDLE; returns to IDLE.
  task automatic run_nominal();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Abort in IDLE, nominal bottle, abort during DONE
    add(0,0,1,0, 3'd0, 8'd0);
    add(1,1,0,0, 3'd1, 8'd0);
    for (int i = 0; i < 4; i++) add(0,1,0,0, 3'd2, 8'd0);
    add(0,1,0,0, 3'd3, 8'd0); add(0,1,0,0, 3'd3, 8'd0);
    add(0,1,0,0, 3'd4, 8'd1);
    add(0,0,1,0, 3'd0, 8'd1);
    // Sensor timeout
    add(1,0,0,0, 3'd1, 8'd1); add(0,0,0,0, 3'd1, 8'd1); add(0,0,0,0, 3'd1, 8'd1);
    add(0,0,0,0, 3'd5, 8'd1); add(0,0,0,0, 3'd5, 8'd1); add(0,0,0,1, 3'd0, 8'd1);
    // Bottle removed on 2nd FILL cycle
    add(1,1,0,0, 3'd1, 8'd1); add(0,1,0,0, 3'd2, 8'd1); add(0,1,0,0, 3'd2, 8'd1);
    add(0,0,0,0, 3'd5, 8'd1); add(0,0,0,1, 3'd0, 8'd1);
    // Abort beats sensor in CHECK
    add(1,1,0,0, 3'd1, 8'd1); add(0,1,1,0, 3'd5, 8'd1); add(0,0,0,1, 3'd0, 8'd1);
    // Abort held in SEAL with clear_fault
    add(1,1,0,0, 3'd1, 8'd1);
    for (int i = 0; i < 4; i++) add(0,1,0,0, 3'd2, 8'd1);
    add(0,1,0,0, 3'd3, 8'd1);
    add(0,1,1,1, 3'd5, 8'd1); add(0,1,1,1, 3'd5, 8'd1); add(0,0,0,1, 3'd0, 8'd1);
    // Second bottle with start held (ignored) through FILL/SEAL
    add(1,1,0,0, 3'd1, 8'd1);
    for (int i = 0; i < 4; i++) add(1,1,0,0, 3'd2, 8'd1);
    add(1,1,0,0, 3'd3, 8'd1); add(1,1,0,0, 3'd3, 8'd1);
    add(1,1,0,0, 3'd4, 8'd2);
    add(0,0,0,0, 3'd0, 8'd2);

    @(posedge clk);
    #1;
    chk_all("por", 3'd0, 8'd0);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].s, vq[i].b, vq[i].a, vq[i].c);
      chk_all($sformatf("vec%0d", i), vq[i].st, vq[i].cnt);
    end

    // Saturation with CNT_W=2 alongside the 8-bit instance
    do_reset();
    for (int n = 1; n <= 4; n++) begin
      run_nominal();
      chk($sformatf("sat2_%0d", n), {30'd0, bottle_count2}, (n > 3) ? 32'd3 : n);
      chk($sformatf("cnt8_%0d", n), {24'd0, bottle_count}, n);
    end

    // Async reset mid-FILL, observed before any clock edge
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk_all("pre_rst_fill", 3'd2, 8'd4);
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 3'd0, 8'd0);
    chk("async_rst.cnt2", {30'd0, bottle_count2}, 32'd0);
    start = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Held start after DONE
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_all("held.check", 3'd1, 8'd0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_all("held.fill", 3'd2, 8'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_all("held.seal", 3'd3, 8'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_all("held.done", 3'd4, 8'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
`ifdef AUTO_CYCLE_EN
    chk_all("held.auto_check", 3'd1, 8'd1);
`else
    chk_all("held.idle", 3'd0, 8'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_all("held.recheck", 3'd1, 8'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
